lin_master_sched_ctrl: RTL

Parametrised LIN master mode controller: the next generation of the master controller. Sequences init, normal scheduling, collision resolution, diagnostic and sleep modes. Adds multi-table selection with frame-boundary switching, a bounded wake-up retry procedure and bus-error escalation. Sits between the APB register block and the LIN frame engine / schedule-table ROMs.

---
 rtl/lin_master_sched_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lin_master_sched_ctrl.sv
// LIN master mode controller: init, scheduling, collision, diagnostic, wake-up and sleep sequencing
// with frame-boundary table switching, bounded wake retries and bus-error escalation.
module lin_master_sched_ctrl #(
   parameter int INIT_CYCLES  = 30,
   parameter int CNT_W        = 8,
   parameter int N_TABLES     = 4,
   parameter int TBL_W        = 2,
   parameter int WAKE_PULSE   = 4,
   parameter int WAKE_WAIT    = 20,
   parameter int WAKE_RETRIES = 3,
   parameter int ERR_LIMIT    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_schedule,
   input  logic [TBL_W-1:0] table_sel,
   input  logic             frame_done,
   input  logic             sleep_cmd,
   input  logic             bus_inactive,
   input  logic             bus_error,
   input  logic             wakeup,
   input  logic             collision_detected,
   input  logic             collision_resolved,
   input  logic             diagnostic_rcvd,
   input  logic             diag_done,
   output logic             init_start,
   output logic             init_finish,
   output logic             en_operation,
   output logic             read_from_mem,
   output logic             en_collision_table,
   output logic             en_diagnostic_table,
   output logic             wake_cluster,
   output logic [TBL_W-1:0] active_table,
   output logic             wake_fail,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_RUN   = 3'd1,
      S_COLL  = 3'd2,
      S_DIAG  = 3'd3,
      S_WAKE  = 3'd4,
      S_SLEEP = 3'd5
   } state_t;

   localparam int ATT_W = $clog2(WAKE_RETRIES + 1);
   localparam int ERR_W = $clog2(ERR_LIMIT + 1);

   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(WAKE_PULSE);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAKE_PULSE + WAKE_WAIT - 1);
   localparam logic [ATT_W-1:0] ATT_LAST  = ATT_W'(WAKE_RETRIES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = ERR_W'(ERR_LIMIT);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] tmr;
   logic [CNT_W-1:0] tmr_nxt;
   logic [ATT_W-1:0] att;
   logic [ATT_W-1:0] att_nxt;
   logic [ERR_W-1:0] err_cnt;
   logic [ERR_W-1:0] err_nxt;
   logic             wake_fail_nxt;
   logic [TBL_W-1:0] pending;

   always_comb begin
      state_nxt     = state;
      tmr_nxt       = tmr;
      att_nxt       = att;
      wake_fail_nxt = wake_fail;
      case (state)
         S_INIT: begin
            if (tmr == INIT_LAST) state_nxt = S_RUN;
            else                  tmr_nxt   = tmr + 1'b1;
         end
         S_RUN: begin
            if (sleep_cmd)                             state_nxt = S_SLEEP;
            else if (err_cnt == ERR_MAX)               state_nxt = S_INIT;
            else if (collision_detected)               state_nxt = S_COLL;
            else if (diagnostic_rcvd && !en_schedule)  state_nxt = S_DIAG;
            else if (bus_inactive)                     state_nxt = S_WAKE;
         end
         S_COLL: begin
            if (sleep_cmd)               state_nxt = S_SLEEP;
            else if (collision_resolved) state_nxt = S_RUN;
         end
         S_DIAG: begin
            if (sleep_cmd)      state_nxt = S_SLEEP;
            else if (diag_done) state_nxt = S_RUN;
         end
         S_WAKE: begin
            // Bus activity only counts once the pulse is over; our own pulse would otherwise satisfy it.
            if (sleep_cmd) begin
               state_nxt = S_SLEEP;
            end else if ((tmr >= PULSE_END) && !bus_inactive) begin
               state_nxt = S_RUN;
            end else if (tmr == WAIT_LAST) begin
               if (att == ATT_LAST) begin
                  wake_fail_nxt = 1'b1;
                  state_nxt     = S_SLEEP;
               end else begin
                  att_nxt = att + 1'b1;
                  tmr_nxt = '0;
               end
            end else begin
               tmr_nxt = tmr + 1'b1;
            end
         end
         S_SLEEP: begin
            if (wakeup) begin
               state_nxt     = S_INIT;
               wake_fail_nxt = 1'b0;
            end
         end
         default: state_nxt = S_INIT;
      endcase
      if (state_nxt != state) begin
         tmr_nxt = '0;
         att_nxt = '0;
      end
   end

   always_comb begin
      err_nxt = err_cnt;
      if ((state_nxt == S_INIT) && (state != S_INIT)) err_nxt = '0;
      else if (bus_error) err_nxt = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;
      else if (frame_done) err_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= S_INIT;
         tmr                 <= '0;
         att                 <= '0;
         err_cnt             <= '0;
         wake_fail           <= 1'b0;
         pending             <= '0;
         active_table        <= '0;
         init_start          <= 1'b1;
         init_finish         <= 1'b0;
         en_operation        <= 1'b0;
         read_from_mem       <= 1'b0;
         en_collision_table  <= 1'b0;
         en_diagnostic_table <= 1'b0;
         wake_cluster        <= 1'b0;
         state_o             <= 3'd0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         att       <= att_nxt;
         err_cnt   <= err_nxt;
         wake_fail <= wake_fail_nxt;
         // Out-of-range requests are dropped so the ROM is never addressed with a missing table.
         if (int'(table_sel) < N_TABLES) pending <= table_sel;
         if (frame_done || !en_schedule) active_table <= pending;
         init_start          <= (state_nxt == S_INIT);
         init_finish         <= (state == S_INIT) && (state_nxt == S_RUN);
         en_operation        <= ((state_nxt == S_RUN) && en_schedule) ||
                                (state_nxt == S_COLL) || (state_nxt == S_DIAG);
         read_from_mem       <= ((state_nxt == S_RUN) && en_schedule) ||
                                (state_nxt == S_COLL) || (state_nxt == S_DIAG);
         en_collision_table  <= (state_nxt == S_COLL);
         en_diagnostic_table <= (state_nxt == S_DIAG);
         wake_cluster        <= (state_nxt == S_WAKE) && (tmr_nxt < PULSE_END);
         state_o             <= state_nxt;
      end
   end

endmodule
